mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AddrWidth, default 32, byte address width of all address ports.
REQ-002 Parameter LineSize, default 128, cache line width in bits (4 words of 32 bits).
REQ-003 Parameter OffsetBits, default 4, byte-offset bits cleared when the line address is aligned.
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 req0_read_en_i  input  1  requester 0 (instruction cache) line-fill request, held until served.
REQ-007 req0_addr_i  input  AddrWidth  requester 0 miss address.
REQ-008 req0_valid_o  output  1  one-cycle pulse: req0_data_o holds the requested line.
REQ-009 req0_data_o  output  LineSize  line returned to requester 0.
REQ-010 req1_read_en_i, req1_addr_i, req1_valid_o, req1_data_o  same as REQ-006..009, for requester 1 (data cache).
REQ-011 mem_addr_o  output  AddrWidth  line-aligned address to memory.
REQ-012 mem_read_en_o  output  1  memory read command, one-cycle pulse.
REQ-013 mem_read_valid_i  input  1  memory response strobe.
REQ-014 mem_read_data_i  input  LineSize  memory response line.
REQ-015 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: if any reqN_read_en_i is high, the block SHALL register the winner, latch its address with bits [OffsetBits-1:0] cleared, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: a single requester wins alone; with both requesting, the winner is the requester not granted last.
REQ-019 The last-grant register SHALL update only on a grant and SHALL reset to requester 1, so requester 0 wins the first contention.
REQ-020 ISSUE: mem_read_en_o SHALL be 1 for exactly this one cycle, with mem_addr_o = latched aligned address; next state WAIT.
REQ-021 mem_addr_o SHALL hold the latched address in ISSUE and WAIT and be 0 in IDLE and RESP.
REQ-022 WAIT: on mem_read_valid_i=1 the block SHALL register mem_read_data_i and go to RESP; otherwise it SHALL stay in WAIT with no timeout.
REQ-023 RESP: the granted reqN_valid_o SHALL be 1 for one cycle and reqN_data_o SHALL show the registered line; next state IDLE.
REQ-024 The valid pulse SHALL be suppressed if the granted requester's read_en_i is low in RESP; the line is discarded.
REQ-025 Outside RESP, every reqN_valid_o SHALL be 0; the non-granted requester's valid SHALL never assert.
REQ-026 mem_read_valid_i outside WAIT SHALL be ignored, with no state or data change.
REQ-027 Latency, request at cycle 0 in IDLE and memory response at cycle M: mem_read_en_o at cycle 1, reqN_valid_o at cycle M+1, IDLE at M+2, next issue no earlier than M+3.
REQ-028 Requester address changes after grant SHALL NOT affect mem_addr_o for the transaction in flight.
REQ-029 Only one memory transaction SHALL be outstanding at any time.

Reset
REQ-030 While rst_i=1 the block SHALL force IDLE, last-grant=1, and all outputs to 0 (data outputs and the registered line included), independent of clk_i.
REQ-031 Reset asserted in ISSUE, WAIT or RESP SHALL abort the transaction with no valid pulse; a late memory response arriving in IDLE SHALL be ignored per REQ-026.

Verification
REQ-032 Single request: req0 with addr 0x0000_1234, memory answers 3 cycles after the command with line L -> mem_addr_o=0x0000_1230, mem_read_en_o pulses once, req0_valid_o pulses once carrying L, req1_valid_o stays 0.
REQ-033 Contention: req0 and req1 held high from reset -> grant order req0, req1, req0, req1 over four back-to-back transactions, each returning its own line.
REQ-034 Requester drop: req1 deasserts read_en during WAIT -> memory response consumed, req1_valid_o stays 0, FSM returns to IDLE.
REQ-035 Spurious strobe: mem_read_valid_i pulsed in IDLE and in ISSUE -> no valid pulse and no state change; transaction completes only on the strobe in WAIT.
REQ-036 Reset mid-WAIT: rst_i asserted for 2 cycles during WAIT, then memory strobes -> outputs 0 immediately, no valid pulse, next request issues normally with req0 winning contention.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Two-requester round-robin line-fill arbiter in front of a single-outstanding
// memory read port. One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP.
module mem_arbiter #(
  parameter int AddrWidth  = 32,
  parameter int LineSize   = 128,
  parameter int OffsetBits = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req0_read_en_i,
  input  logic [AddrWidth-1:0] req0_addr_i,
  output logic                 req0_valid_o,
  output logic [LineSize-1:0]  req0_data_o,
  input  logic                 req1_read_en_i,
  input  logic [AddrWidth-1:0] req1_addr_i,
  output logic                 req1_valid_o,
  output logic [LineSize-1:0]  req1_data_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_read_en_o,
  input  logic                 mem_read_valid_i,
  input  logic [LineSize-1:0]  mem_read_data_i,
  output logic                 busy_o
);

  localparam logic [AddrWidth-1:0] AlignMask =
    {{(AddrWidth-OffsetBits){1'b1}}, {OffsetBits{1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic                  grant_q;       // requester owning the in-flight transaction
  logic                  last_grant_q;  // requester granted most recently
  logic                  winner;
  logic                  grant_en;
  logic [AddrWidth-1:0]  addr_q;
  logic [LineSize-1:0]   line_q;

  // Round-robin pick: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    winner = 1'b0;
    if (req0_read_en_i && req1_read_en_i) begin
      winner = ~last_grant_q;
    end else if (req1_read_en_i) begin
      winner = 1'b1;
    end
    grant_en = (state_q == IDLE) && (req0_read_en_i || req1_read_en_i);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (grant_en) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (mem_read_valid_i) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant bookkeeping and aligned address capture, updated only when a grant is made.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
    end else if (grant_en) begin
      grant_q      <= winner;
      last_grant_q <= winner;
      addr_q       <= (winner ? req1_addr_i : req0_addr_i) & AlignMask;
    end
  end

  // Memory response capture; strobes outside WAIT are ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q <= '0;
    end else if (state_q == WAIT && mem_read_valid_i) begin
      line_q <= mem_read_data_i;
    end
  end

  assign mem_read_en_o = (state_q == ISSUE);
  assign mem_addr_o    = (state_q == ISSUE || state_q == WAIT) ? addr_q : '0;
  assign busy_o        = (state_q != IDLE);
  assign req0_valid_o  = (state_q == RESP) && !grant_q && req0_read_en_i;
  assign req1_valid_o  = (state_q == RESP) &&  grant_q && req1_read_en_i;
  assign req0_data_o   = line_q;
  assign req1_data_o   = line_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_arbiter: the driver predicts grants and lines with a
// round-robin reference model; a monitor pops and compares on every output pulse.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_read_en_i, req1_read_en_i;
  logic [31:0]  req0_addr_i, req1_addr_i;
  logic         req0_valid_o, req1_valid_o;
  logic [127:0] req0_data_o, req1_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_read_en_o;
  logic         mem_read_valid_i;
  logic [127:0] mem_read_data_i;
  logic         busy_o;

  int total = 0;
  int bad   = 0;

  logic [31:0]  exp_addr_q[$];
  bit           exp_id_q[$];
  logic [127:0] exp_line_q[$];
  bit           model_last;

  always #5 clk = ~clk;

  mem_arbiter #(.AddrWidth(32), .LineSize(128), .OffsetBits(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req0_read_en_i   (req0_read_en_i),
    .req0_addr_i      (req0_addr_i),
    .req0_valid_o     (req0_valid_o),
    .req0_data_o      (req0_data_o),
    .req1_read_en_i   (req1_read_en_i),
    .req1_addr_i      (req1_addr_i),
    .req1_valid_o     (req1_valid_o),
    .req1_data_o      (req1_data_o),
    .mem_addr_o       (mem_addr_o),
    .mem_read_en_o    (mem_read_en_o),
    .mem_read_valid_i (mem_read_valid_i),
    .mem_read_data_i  (mem_read_data_i),
    .busy_o           (busy_o)
  );

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every valid pulse and every memory command is matched to the scoreboard.
  always @(negedge clk) begin
    #2;
    if (req0_valid_o || req1_valid_o) begin
      check_b("single_valid", req0_valid_o && req1_valid_o, 1'b0);
      if (exp_id_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got v0=%b v1=%b want none", req0_valid_o, req1_valid_o);
      end else begin
        bit           id;
        logic [127:0] line;
        id   = exp_id_q.pop_front();
        line = exp_line_q.pop_front();
        check_b("valid_id", req1_valid_o, id);
        check_w("valid_data", id ? req1_data_o : req0_data_o, line);
      end
    end
    if (mem_read_en_o) begin
      if (exp_addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_mem_cmd: got addr %h want none", mem_addr_o);
      end else begin
        check_w("mem_addr", 128'(mem_addr_o), 128'(exp_addr_q.pop_front()));
      end
    end
  end

  // One transaction. Called at a negedge with the DUT in IDLE.
  task automatic do_txn(input bit r0, input bit r1, input logic [31:0] a0, input logic [31:0] a1,
                        input int dly, input bit drop, input bit spur);
    bit           w;
    logic [31:0]  exp_a;
    logic [127:0] line;
    w          = (r0 && r1) ? !model_last : r1;
    model_last = w;
    exp_a      = (w ? a1 : a0) & 32'hFFFF_FFF0;
    exp_addr_q.push_back(exp_a);
    req0_read_en_i = r0;
    req1_read_en_i = r1;
    req0_addr_i    = a0;
    req1_addr_i    = a1;
    @(negedge clk);
    check_b("issue_cmd", mem_read_en_o, 1'b1);
    check_b("issue_busy", busy_o, 1'b1);
    if (mem_read_en_o !== 1'b1) begin
      $display("FAIL issue_timeout: got no command want command one cycle after request");
      bad++;
      summary();
    end
    req0_addr_i = $urandom;
    req1_addr_i = $urandom;
    if (spur) begin
      mem_read_valid_i = 1'b1;
      mem_read_data_i  = rand_line();
    end
    @(negedge clk);
    mem_read_valid_i = 1'b0;
    check_b("wait_cmd_low", mem_read_en_o, 1'b0);
    check_w("wait_addr_hold", 128'(mem_addr_o), 128'(exp_a));
    repeat (dly - 1) @(negedge clk);
    check_b("wait_still_busy", busy_o, 1'b1);
    line             = rand_line();
    mem_read_valid_i = 1'b1;
    mem_read_data_i  = line;
    if (drop) begin
      if (w) req1_read_en_i = 1'b0;
      else   req0_read_en_i = 1'b0;
    end else begin
      exp_id_q.push_back(w);
      exp_line_q.push_back(line);
    end
    @(negedge clk);
    mem_read_valid_i = 1'b0;
    check_b("resp_valid", w ? req1_valid_o : req0_valid_o, !drop);
    check_b("resp_other_valid", w ? req0_valid_o : req1_valid_o, 1'b0);
    check_w("resp_addr_zero", 128'(mem_addr_o), 128'd0);
    @(negedge clk);
    check_b("back_to_idle", busy_o, 1'b0);
  endtask

  task automatic idle(input int n, input bit strobe);
    req0_read_en_i   = 1'b0;
    req1_read_en_i   = 1'b0;
    mem_read_valid_i = strobe;
    mem_read_data_i  = rand_line();
    repeat (n) begin
      @(negedge clk);
      mem_read_valid_i = 1'b0;
      check_b("idle_busy", busy_o, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_b({tag, "_busy"}, busy_o, 1'b0);
    check_b({tag, "_cmd"}, mem_read_en_o, 1'b0);
    check_w({tag, "_addr"}, 128'(mem_addr_o), 128'd0);
    check_b({tag, "_v0"}, req0_valid_o, 1'b0);
    check_b({tag, "_v1"}, req1_valid_o, 1'b0);
    check_w({tag, "_d0"}, req0_data_o, 128'd0);
    check_w({tag, "_d1"}, req1_data_o, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    bad++;
    summary();
  end

  initial begin
    rst              = 1'b1;
    req0_read_en_i   = 1'b0;
    req1_read_en_i   = 1'b0;
    req0_addr_i      = '0;
    req1_addr_i      = '0;
    mem_read_valid_i = 1'b0;
    mem_read_data_i  = '0;
    model_last       = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Contention from reset: req0, req1, req0, req1.
    for (int i = 0; i < 4; i++) do_txn(1'b1, 1'b1, $urandom, $urandom, 2, 1'b0, 1'b0);
    idle(1, 1'b0);

    // Single request with a fixed misaligned address, response 3 cycles after the command.
    do_txn(1'b1, 1'b0, 32'h0000_1234, 32'h0, 3, 1'b0, 1'b0);

    // Requester 1 drops during WAIT.
    do_txn(1'b0, 1'b1, $urandom, $urandom, 2, 1'b1, 1'b0);

    // Spurious strobes in IDLE and in ISSUE.
    idle(2, 1'b1);
    do_txn(1'b0, 1'b1, $urandom, $urandom, 3, 1'b0, 1'b1);

    // Reset asserted mid-WAIT, then a late memory strobe.
    begin
      req0_read_en_i = 1'b1;
      req0_addr_i    = $urandom;
      exp_addr_q.push_back(req0_addr_i & 32'hFFFF_FFF0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      model_last = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(2, 1'b1);
      do_txn(1'b1, 1'b1, $urandom, $urandom, 1, 1'b0, 1'b0);
    end

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int unsigned r;
      r = $urandom_range(1, 3);
      do_txn(r[0], r[1], $urandom, $urandom, $urandom_range(1, 4),
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2), $urandom_range(0, 1) == 1);
    end
    idle(2, 1'b0);

    check_w("scoreboard_resp_drain", 128'(exp_id_q.size()), 128'd0);
    check_w("scoreboard_addr_drain", 128'(exp_addr_q.size()), 128'd0);
    summary();
  end

endmodule
